// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Conditions the raw, bouncy, asynchronous active-low push-button pins before
//   they reach the key PIO. Each key passes through a 2-flop synchronizer and
//   then an independent debounce counter. A new level is accepted only after it
//   has been seen for DEBOUNCE_CYCLES consecutive cycles. The debounced output
//   is still active-low, so software sees the same polarity as before. Each
//   accepted edge also raises a registered one-cycle press or release strobe
//   for local hardware consumers.
//
// Ports
//   clk            in   1         system clock (PIO clock domain)
//   reset          in   1         asynchronous, active-high reset
//   key_n_in       in   NUM_KEYS  raw key pins, active-low, asynchronous to clk
//   key_n_db       out  NUM_KEYS  debounced level, active-low
//   press_pulse    out  NUM_KEYS  1-cycle strobe when key_n_db[i] falls (1->0)
//   release_pulse  out  NUM_KEYS  1-cycle strobe when key_n_db[i] rises (0->1)
//
// Parameters
//   NUM_KEYS         number of independent key channels
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a change (>= 2)
//   CNT_W            counter width, 2**CNT_W > DEBOUNCE_CYCLES
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n_in,
  output logic [NUM_KEYS-1:0] key_n_db,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);

  // Per-key mode, derived from comparing the synchronized input with the
  // accepted level. The real state is held in db_q and cnt_q.
  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } key_state_e;

  // Terminal count. Reaching it with the mismatch still present accepts the
  // new level, so the counter never has to wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [NUM_KEYS-1:0] db_q,      db_d;
  logic [NUM_KEYS-1:0] press_q,   press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
  key_state_e          state [NUM_KEYS];

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. Only sync2_q is used downstream. Reset drives it to
  // the released level so a key held through reset looks like a new press.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every flop
      // samples its old inputs on the same edge, so sync2_q picks up the
      // previous sync1_q and not the value being written on this edge.
      sync1_q <= key_n_in;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-key debounce: next-state and strobe logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: each always_comb output gets a default before any branch. If some
    // path left a signal unassigned, synthesis would infer a latch to hold it.
    db_d      = db_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_d[i] = '0;
      state[i] = (sync2_q[i] == db_q[i]) ? ST_STABLE : ST_COUNTING;

      case (state[i])
        ST_STABLE: begin
          // Any single cycle where the input returns to the accepted level
          // discards the partial count.
          cnt_d[i] = '0;
        end
        ST_COUNTING: begin
          if (cnt_q[i] == CNT_LAST) begin
            db_d[i]      = sync2_q[i];
            cnt_d[i]     = '0;
            // Falling active-low level = press, rising = release. Only one of
            // the two can fire because db_q holds a single bit per key.
            press_d[i]   = ~sync2_q[i];
            release_d[i] =  sync2_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: cnt_d[i] = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q      <= '1;
      press_q   <= '0;
      release_q <= '0;
      // NOTE: the counter array is a small bank of flops, not a RAM, so it is
      // reset with everything else. Reset must throw away a partial count.
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_q      <= db_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // All outputs come straight from flops. No combinational path from the pins.
  assign key_n_db      = db_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//   Bench for key_debounce with DEBOUNCE_CYCLES=4 and CNT_W=3. On every cycle
//   the stimulus side computes the expected outputs for the coming edge and
//   queues them. The reference model uses a sliding-window rule: a key's
//   accepted level flips at edge n when the levels it sampled at edges
//   n-5 .. n-2 all differ from the accepted level. Edges under reset count as
//   released. A monitor pops one entry after every clock edge and compares it
//   with the DUT outputs. Directed sequences add fixed expected values around
//   the latency boundary.
// -----------------------------------------------------------------------------
module tb_key_debounce;

  localparam int NK  = 4;
  localparam int DEB = 4;

  logic          clk      = 1'b0;
  logic          reset    = 1'b0;
  logic [NK-1:0] key_n_in = '0;
  logic [NK-1:0] key_n_db;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;

  key_debounce #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_n_in      (key_n_in),
    .key_n_db      (key_n_db),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  always #5 clk = ~clk;

  // Number of posedges seen so far. Before edge k is taken, edge_cnt == k.
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int            edge_no;
    logic [NK-1:0] db;
    logic [NK-1:0] pr;
    logic [NK-1:0] rl;
  } exp_t;

  exp_t          exp_q[$];
  logic [NK-1:0] hist[$];     // level captured by the first sync stage at each edge
  logic [NK-1:0] db_m = '1;   // model's accepted level

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Drive one clock cycle. The stimulus is applied on the falling edge, the
  // expected result for the following rising edge is queued, and the task
  // returns just after that rising edge.
  task automatic cyc(input logic [NK-1:0] keys, input logic rst_v);
    exp_t e;
    int   k;
    @(negedge clk);
    reset    = rst_v;
    key_n_in = keys;
    k        = edge_cnt;
    while (hist.size() < k) hist.push_back('1);
    hist.push_back(rst_v ? '1 : keys);
    e.edge_no = k;
    e.pr      = '0;
    e.rl      = '0;
    if (rst_v) begin
      db_m = '1;
    end else if (k >= DEB + 1) begin
      for (int i = 0; i < NK; i++) begin
        logic all_diff;
        all_diff = 1'b1;
        for (int j = k - DEB - 1; j <= k - 2; j++) begin
          if (hist[j][i] == db_m[i]) all_diff = 1'b0;
        end
        if (all_diff) begin
          if (db_m[i]) e.pr[i] = 1'b1;
          else         e.rl[i] = 1'b1;
          db_m[i] = ~db_m[i];
        end
      end
    end
    e.db = db_m;
    exp_q.push_back(e);
    if (rst_v) begin
      #1;
      chk("reset_outputs", {20'h0, key_n_db, press_pulse, release_pulse}, 32'hF00);
    end
    @(posedge clk);
    #2;
  endtask

  // Hold 'keys' from edge E0 on and check the edges around the acceptance
  // boundary: no change at E0+4, a change plus one strobe at E0+5, and the
  // strobe gone at E0+6.
  task automatic latency_probe(input string nm, input logic [NK-1:0] keys,
                               input logic [NK-1:0] db_before, input logic [NK-1:0] db_after,
                               input logic [NK-1:0] pr_exp, input logic [NK-1:0] rl_exp);
    for (int t = 0; t <= 6; t++) begin
      cyc(keys, 1'b0);
      if (t == 4) chk({nm, "_early"}, {20'h0, key_n_db, press_pulse, release_pulse},
                      {20'h0, db_before, 8'h00});
      if (t == 5) chk({nm, "_edge"},  {20'h0, key_n_db, press_pulse, release_pulse},
                      {20'h0, db_after, pr_exp, rl_exp});
      if (t == 6) chk({nm, "_after"}, {20'h0, key_n_db, press_pulse, release_pulse},
                      {20'h0, db_after, 8'h00});
    end
  endtask

  // Scoreboard monitor: one queued entry per clock edge.
  exp_t mon_e;
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("edge_align", edge_cnt - 1, mon_e.edge_no);
      chk("sb_outputs", {20'h0, key_n_db, press_pulse, release_pulse},
          {20'h0, mon_e.db, mon_e.pr, mon_e.rl});
    end
  end

  logic [NK-1:0] tgt;
  logic [NK-1:0] drv;
  int            gl [NK];

  initial begin
    #1 reset = 1'b1;

    // 1: reset held with every key pressed, then release reset with key 0 held.
    repeat (3) cyc(4'b0000, 1'b1);
    latency_probe("t1_press", 4'b1110, 4'b1111, 4'b1110, 4'b0001, 4'b0000);
    latency_probe("t1_rel",   4'b1111, 4'b1110, 4'b1111, 4'b0000, 4'b0001);

    // 2: clean press and release of key 1, then press it again and keep it held.
    latency_probe("t2_press", 4'b1101, 4'b1111, 4'b1101, 4'b0010, 4'b0000);
    latency_probe("t2_rel",   4'b1111, 4'b1101, 4'b1111, 4'b0000, 4'b0010);
    latency_probe("t2_hold",  4'b1101, 4'b1111, 4'b1101, 4'b0010, 4'b0000);

    // 3: key 2 bounces (3 low, 1 high, 3 low, 1 high). Nothing may change.
    //    After that it is held low long enough to be accepted.
    begin
      logic [NK-1:0] pat [8];
      pat = '{4'b1001, 4'b1001, 4'b1001, 4'b1101, 4'b1001, 4'b1001, 4'b1001, 4'b1101};
      for (int t = 0; t < 8; t++) begin
        cyc(pat[t], 1'b0);
        chk("t3_bounce", {20'h0, key_n_db, press_pulse, release_pulse}, 32'hD00);
      end
    end
    latency_probe("t3_accept", 4'b1001, 4'b1101, 4'b1001, 4'b0100, 4'b0000);

    // 4: release keys 1 and 2, then press keys 0 and 3 on the same cycle.
    latency_probe("t4_prep", 4'b1111, 4'b1001, 4'b1111, 4'b0000, 4'b0110);
    latency_probe("t4_dual", 4'b0110, 4'b1111, 4'b0110, 4'b1001, 4'b0000);

    // 5: release everything, press key 3, then reset after the count reaches 2.
    latency_probe("t5_prep", 4'b1111, 4'b0110, 4'b1111, 4'b0000, 4'b1001);
    repeat (4) cyc(4'b0111, 1'b0);
    chk("t5_midcount", {20'h0, key_n_db, press_pulse, release_pulse}, 32'hF00);
    repeat (3) cyc(4'b0111, 1'b1);
    latency_probe("t5_rearm", 4'b0111, 4'b1111, 4'b0111, 4'b1000, 4'b0000);

    // 6: random levels with 1-3 cycle glitches on all keys.
    tgt = 4'b0111;
    for (int i = 0; i < NK; i++) gl[i] = 0;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < NK; i++) begin
        if (gl[i] > 0) begin
          drv[i] = ~tgt[i];
          gl[i]--;
        end else if ($urandom_range(0, 19) == 0) begin
          gl[i]  = int'($urandom_range(1, 3)) - 1;
          drv[i] = ~tgt[i];
        end else begin
          if ($urandom_range(0, 59) == 0) tgt[i] = ~tgt[i];
          drv[i] = tgt[i];
        end
      end
      cyc(drv, 1'b0);
    end
    repeat (8) cyc(4'b1111, 1'b0);
    chk("final_level", {28'h0, key_n_db}, 32'hF);

    @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
